// File: rtl/pwm_ctrl_pkg.sv
// pwm_ctrl_pkg: shared state encoding, full-scale constant and target clamp for the PWM ramp controller.
package pwm_ctrl_pkg;

    typedef enum logic {ST_IDLE, ST_RAMP} state_t;

    localparam int PWM_R = 8;

    function automatic logic [31:0] full_scale(input int r);
        return 32'(1) << r;
    endfunction

    localparam logic [31:0] FULL_SCALE = full_scale(PWM_R);

    function automatic logic [31:0] clamp_target(input logic [31:0] t, input logic [31:0] fs);
        return (t > fs) ? fs : t;
    endfunction

endpackage

// File: rtl/pwm_dwell_cnt.sv
// pwm_dwell_cnt: counts PWM periods and flags the period that completes a dwell interval.
module pwm_dwell_cnt #(
    parameter int DWELL_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_clear,
    input  logic                  i_period_end,
    input  logic [DWELL_BITS-1:0] i_dwell,
    output logic                  o_step
);

    logic [DWELL_BITS-1:0] r_cnt;

    // Combinational so the duty step lands on the edge that samples period_end.
    assign o_step = i_period_end && (r_cnt == i_dwell - DWELL_BITS'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_cnt <= '0;
        else if (i_clear)
            r_cnt <= '0;
        else if (i_period_end)
            r_cnt <= o_step ? '0 : r_cnt + DWELL_BITS'(1);
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: accepts ramp commands and walks the PWM duty one step at a time toward the target.
module pwm_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int R          = PWM_R,
    parameter int TIMER_BITS = 15,
    parameter int DWELL_BITS = 8,
    parameter int FINAL_INIT = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [R:0]            cmd_target,
    input  logic [DWELL_BITS-1:0] cmd_dwell,
    input  logic [TIMER_BITS-1:0] cmd_final_value,
    input  logic                  period_end,
    input  logic                  abort,
    output logic [R:0]            duty,
    output logic [TIMER_BITS-1:0] final_value,
    output logic                  busy,
    output logic                  done
);

    localparam logic [R:0] FS = (R + 1)'(full_scale(R));

    state_t                r_state, w_state_nxt;
    logic [R:0]            r_duty, r_target, w_target, w_next_duty;
    logic [DWELL_BITS-1:0] r_dwell, w_dwell;
    logic [TIMER_BITS-1:0] r_final;
    logic                  r_done;
    logic                  w_accept, w_step, w_reach, w_adv;

    assign w_target    = (R + 1)'(clamp_target(32'(cmd_target), 32'(FS)));
    assign w_dwell     = (cmd_dwell == '0) ? DWELL_BITS'(1) : cmd_dwell;
    assign w_accept    = cmd_valid && cmd_ready;
    assign w_next_duty = (r_target > r_duty) ? r_duty + (R + 1)'(1) : r_duty - (R + 1)'(1);
    assign w_reach     = (w_next_duty == r_target);
    // Abort outranks a coincident step, so the duty freezes where it was.
    assign w_adv       = (r_state == ST_RAMP) && w_step && !abort;

    pwm_dwell_cnt #(.DWELL_BITS(DWELL_BITS)) u_dwell (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_clear     (w_accept),
        .i_period_end(period_end && (r_state == ST_RAMP)),
        .i_dwell     (r_dwell),
        .o_step      (w_step)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_IDLE)
            w_state_nxt = (w_accept && (w_target != r_duty)) ? ST_RAMP : ST_IDLE;
        else if (abort || (w_step && w_reach))
            w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_duty   <= '0;
            r_target <= '0;
            r_dwell  <= DWELL_BITS'(1);
            r_final  <= TIMER_BITS'(FINAL_INIT);
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_target <= w_target;
                r_dwell  <= w_dwell;
                r_final  <= cmd_final_value;
                r_done   <= (w_target == r_duty);
            end
            if (w_adv) begin
                r_duty <= w_next_duty;
                r_done <= w_reach;
            end
        end
    end

    // Ready stays low through the done cycle so the next accept follows it.
    assign cmd_ready   = (r_state == ST_IDLE) && !r_done;
    assign busy        = (r_state == ST_RAMP);
    assign duty        = r_duty;
    assign final_value = r_final;
    assign done        = r_done;

endmodule

// File: doc/pwm_ramp_ctrl.md
# pwm_ramp_ctrl

Command-driven duty-cycle sequencer that sits in front of the PWM generator and drives its `duty` and `FINAL_VALUE` inputs. It accepts one ramp command at a time over a valid/ready handshake. It then steps `duty` by ±1 toward a target, one step every N PWM periods, and pulses `done` on arrival. It gives soft-start, fades and controlled shutdown without software toggling duty every period.

## Interface
- R, 8, PWM resolution; duty is R+1 bits, full scale 2^R.
- TIMER_BITS, 15, width of the PWM prescaler terminal count.
- DWELL_BITS, 8, width of the per-step dwell count.
- FINAL_INIT, 1, reset value of `final_value`.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_target  in  R+1  target duty; values above 2^R are clamped to 2^R.
- cmd_dwell  in  DWELL_BITS  PWM periods per step; 0 is treated as 1.
- cmd_final_value  in  TIMER_BITS  prescaler terminal count applied on accept.
- period_end  in  1  one-clk pulse when the PWM counter wraps.
- abort  in  1  stop the ramp, hold the current duty.
- duty  out  R+1  to the PWM `duty` input.
- final_value  out  TIMER_BITS  to the PWM `FINAL_VALUE` input.
- busy  out  1  ramp in progress.
- done  out  1  one-clk pulse when the target is reached.

## Operation
- States:
  - IDLE: `cmd_ready`=1, `busy`=0.
  - RAMP: `cmd_ready`=0, `busy`=1.
- Accept on `cmd_valid && cmd_ready`:
  - Latch the clamped target and effective dwell (max(cmd_dwell,1)).
  - Load `final_value` with `cmd_final_value`.
  - Clear the dwell counter.
- On accept with target == `duty`: stay in IDLE, pulse `done`.
- On accept with target != `duty`: go to RAMP.
- In RAMP, each `period_end` increments the dwell counter.
  - When the counter equals dwell-1 and `period_end`=1: `duty` steps ±1 toward the target and the counter clears.
  - If the new `duty` equals the target: pulse `done` and return to IDLE.
- `abort` in RAMP: go to IDLE with `duty` frozen and no `done`.
  - Abort wins over a coincident step, including the final step.
- `abort` in IDLE: no effect.
- `period_end` in IDLE: ignored.
- Duty arithmetic is R+1 bits unsigned.
  - Duty never leaves [0, 2^R] and never overshoots the target.
  - No wrap-around.
- `final_value` changes only at accept.

## Timing
- Reset values: `duty`=0, `final_value`=FINAL_INIT, `busy`=0, `done`=0, `cmd_ready`=1, state IDLE, dwell counter 0.
- All outputs are registered; `cmd_ready` is decoded from state.
- Accept at edge k:
  - `final_value` and `busy` update at k+1.
  - The first `period_end` sampled from k+1 onward counts.
- Step latency: `duty` updates on the edge that samples the qualifying `period_end`.
- `done` is registered on the same edge as the final `duty` update; `busy` falls on that same edge.
- `cmd_ready` rises one cycle after `done`, at the first edge after it.
- Back-to-back: a new command can be accepted the cycle after `done`.
- Reset mid-ramp: all outputs return to reset values asynchronously; the ramp is discarded.

## Structure
- Package `pwm_ctrl_pkg` holds:
  - State encoding (IDLE, RAMP).
  - Full-scale constant 2^R.
  - The clamp helper function.
- Sub-module `pwm_dwell_cnt`: DWELL_BITS counter.
  - Inputs: clear, `period_end`, dwell.
  - Output: one-cycle `step` when the count reaches dwell-1.
- Controller FSM, duty register and clamp live in the top level.

## Test plan
- After reset: `duty`=0, `final_value`=1, `cmd_ready`=1, `busy`=0.
- Up-ramp:
  - Stimulus: target=4, dwell=2, period_end every 10 clk.
  - Required: duty steps 1,2,3,4 on every 2nd period_end; `done` pulses once with duty=4; `cmd_ready` high the next cycle.
- Down-ramp plus clamp and zero dwell:
  - Stimulus: from duty=4, target=9'h1FF (clamps to 256), then target=0 with dwell=0.
  - Required: rises to 256; falls to 0 stepping on every period_end.
- Null command: target equal to the current duty → no RAMP entry; `done` one cycle after accept; `busy` stays 0.
- Abort coinciding with the final step: abort in the same cycle as the qualifying period_end → duty held at target-1, no `done`, IDLE.
- Reset mid-ramp and handshake:
  - Stimulus: assert reset_n low mid-ramp; `cmd_valid` held during RAMP.
  - Required: all outputs at reset values immediately; the held command is not accepted until IDLE.
